// File: rtl/npc_io_pkg.sv
// Shared constants and types for the request debouncer.
//   LANES             : number of independent request lanes (8)
//   DB_CYCLES_DEFAULT : default number of consecutive differing cycles
//                       required before a lane's output bit changes
//   lane_vec_t        : one bit per lane
package npc_io_pkg;

    localparam int LANES             = 8;
    localparam int DB_CYCLES_DEFAULT = 4;

    typedef logic [LANES-1:0] lane_vec_t;

endpackage : npc_io_pkg

// File: rtl/req_debounce8_if.sv
// Request-line bundle between the switch side and the debouncer.
//   sw_i     : raw request lines, asynchronous to clk
//   freeze_i : hold outputs and suspend debouncing while high
//   x_o      : debounced request vector (feeds the priority encoder X input)
//   chg_o    : one-cycle pulse in the first cycle x_o shows a new value
//   busy_o   : high while any lane has a pending debounce count
// master drives the raw lines, slave is the debouncer.
interface req_debounce8_if;
    import npc_io_pkg::*;

    lane_vec_t sw_i;
    logic      freeze_i;
    lane_vec_t x_o;
    logic      chg_o;
    logic      busy_o;

    modport master (
        output sw_i,
        output freeze_i,
        input  x_o,
        input  chg_o,
        input  busy_o
    );

    modport slave (
        input  sw_i,
        input  freeze_i,
        output x_o,
        output chg_o,
        output busy_o
    );

endinterface : req_debounce8_if

// File: rtl/db_lane.sv
// One debounce lane: 2-flop synchronizer, consecutive-difference counter
// and the debounced output bit.
//   clk, rst : system clock, synchronous active-high reset
//   freeze   : suspend debouncing (counter held at 0, output held)
//   sw       : raw asynchronous request line
//   x        : debounced output bit (registered)
//   upd      : high in the cycle before x takes a new value (combinational)
//   pend     : counter is nonzero (registered)
module db_lane
    import npc_io_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic freeze,
    input  logic sw,
    output logic x,
    output logic upd,
    output logic pend
);

    localparam int              CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DB_CYCLES - 1);

    // s1_reg may go metastable; nothing but s2_reg looks at it.
    logic          s1_reg;
    logic          s2_reg;
    logic          x_reg;
    logic          x_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // cnt counts edges on which the synchronized input has disagreed with
    // the output; the DB_CYCLES-th such edge commits the new value.
    always_comb begin
        cnt_next = cnt_reg;
        x_next   = x_reg;
        upd      = 1'b0;
        if (freeze || (s2_reg == x_reg)) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
            x_next   = s2_reg;
            cnt_next = '0;
            upd      = 1'b1;
        end else begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg  <= 1'b0;
            s2_reg  <= 1'b0;
            cnt_reg <= '0;
            x_reg   <= 1'b0;
        end else begin
            // synchronizer keeps sampling even while frozen
            s1_reg  <= sw;
            s2_reg  <= s1_reg;
            cnt_reg <= cnt_next;
            x_reg   <= x_next;
        end
    end

    assign x    = x_reg;
    assign pend = (cnt_reg != '0);

endmodule : db_lane

// File: rtl/req_debounce8.sv
// Eight independent request-line debouncers feeding an 8-to-3 priority
// encoder's X input. No priority is applied here.
//   clk : system clock
//   rst : synchronous active-high reset (wins over freeze and pending updates)
//   bus : slave side of req_debounce8_if (sw_i, freeze_i in; x_o, chg_o,
//         busy_o out)
module req_debounce8
    import npc_io_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    req_debounce8_if.slave        bus
);

    lane_vec_t x_vec;
    lane_vec_t upd_vec;
    lane_vec_t pend_vec;
    logic      chg_reg;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        db_lane #(
            .DB_CYCLES (DB_CYCLES)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .freeze (bus.freeze_i),
            .sw     (bus.sw_i[gi]),
            .x      (x_vec[gi]),
            .upd    (upd_vec[gi]),
            .pend   (pend_vec[gi])
        );
    end

    // Registered alongside x: high exactly in the cycle after an edge that
    // changed any lane. Lane upd is already suppressed while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_reg <= 1'b0;
        end else begin
            chg_reg <= |upd_vec;
        end
    end

    assign bus.x_o    = x_vec;
    assign bus.chg_o  = chg_reg;
    assign bus.busy_o = |pend_vec;

endmodule : req_debounce8

// File: tb/tb_req_debounce8.sv
// Self-checking bench for req_debounce8 with DB_CYCLES=4: a reset/glitch
// vector table, directed multi-cycle sequences and randomized traffic, all
// compared against a streak-based reference model.
module tb_req_debounce8;
    import npc_io_pkg::*;

    localparam int DB = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   cyc;

    req_debounce8_if bus ();

    req_debounce8 #(
        .DB_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Two-stage sample delay, then per lane: a new value is accepted once it
    // has disagreed with the output on DB consecutive unfrozen edges.
    logic [7:0] m_s1, m_s2, m_x;
    logic       m_chg;
    int         m_streak [LANES];

    task automatic model_edge(input logic r, input logic f, input logic [7:0] s);
        logic [7:0] flips;
        flips = '0;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_x = '0; m_chg = 1'b0;
            for (int n = 0; n < LANES; n++) m_streak[n] = 0;
        end else begin
            for (int n = 0; n < LANES; n++) begin
                if (f || (m_s2[n] == m_x[n])) begin
                    m_streak[n] = 0;
                end else begin
                    m_streak[n] = m_streak[n] + 1;
                    if (m_streak[n] >= DB) begin
                        flips[n]    = 1'b1;
                        m_streak[n] = 0;
                    end
                end
            end
            m_x   = m_x ^ flips;
            m_chg = (flips != 8'h00);
            m_s2  = m_s1;
            m_s1  = s;
        end
    endtask

    function automatic logic model_busy();
        logic b;
        b = 1'b0;
        for (int n = 0; n < LANES; n++) if (m_streak[n] != 0) b = 1'b1;
        return b;
    endfunction

    // ---------------- helpers ----------------
    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %02h expected %02h", name, cyc, act, exp);
        end
    endtask

    // Drive inputs, clock one edge, advance the model, sample at negedge and
    // compare all outputs against the model.
    task automatic cycle(input logic r, input logic f, input logic [7:0] s);
        rst          = r;
        bus.freeze_i = f;
        bus.sw_i     = s;
        @(posedge clk);
        model_edge(r, f, s);
        @(negedge clk);
        cyc++;
        $display("cyc %0d rst=%b frz=%b sw=%02h -> x=%02h chg=%b busy=%b",
                 cyc, r, f, s, bus.x_o, bus.chg_o, bus.busy_o);
        cmp("model_x", bus.x_o, m_x);
        cmp("model_chg", {7'b0, bus.chg_o}, {7'b0, m_chg});
        cmp("model_busy", {7'b0, bus.busy_o}, {7'b0, model_busy()});
    endtask

    typedef struct {
        logic       r;
        logic       f;
        logic [7:0] sw;
        logic [7:0] x;
        logic       chg;
        logic       busy;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int         chg_cnt;
        int         rise_cnt;
        logic       prev_x0;
        logic [7:0] sw_r;
        int         frz_left;
        logic       r_r;

        n_vec = 0; n_err = 0; cyc = 0;
        rst = 1'b1; bus.freeze_i = 1'b0; bus.sw_i = 8'h00;

        // Reset with all lines high, release, full debounce to FF; then a
        // 3-cycle glitch on lane 3 that must be rejected.
        tbl[0]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].r, tbl[i].f, tbl[i].sw);
            cmp("tbl_x", bus.x_o, tbl[i].x);
            cmp("tbl_chg", {7'b0, bus.chg_o}, {7'b0, tbl[i].chg});
            cmp("tbl_busy", {7'b0, bus.busy_o}, {7'b0, tbl[i].busy});
        end

        // Simultaneous update of lanes 7 and 0: one single-cycle chg pulse.
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        chg_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b0, 8'h81);
            if (bus.chg_o) chg_cnt++;
            if (i < 5) cmp("simul_hold", bus.x_o, 8'h00);
            if (i == 5) begin
                cmp("simul_x", bus.x_o, 8'h81);
                cmp("simul_chg", {7'b0, bus.chg_o}, 8'h01);
            end
        end
        cmp("simul_pulses", 8'(chg_cnt), 8'h01);

        // Freeze: hold 10 while sw moves to 02, then 4 edges after release.
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 8'h10);
        cmp("frz_setup", bus.x_o, 8'h10);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'h02);
            cmp("frz_x", bus.x_o, 8'h10);
            cmp("frz_chg", {7'b0, bus.chg_o}, 8'h00);
            cmp("frz_busy", {7'b0, bus.busy_o}, 8'h00);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 8'h02);
            if (i < 3) cmp("unfrz_hold", bus.x_o, 8'h10);
        end
        cmp("unfrz_x", bus.x_o, 8'h02);
        cmp("unfrz_chg", {7'b0, bus.chg_o}, 8'h01);

        // Reset in the middle of debouncing lane 7.
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h80);
        cycle(1'b1, 1'b0, 8'h80);
        cmp("midrst_x", bus.x_o, 8'h00);
        cmp("midrst_busy", {7'b0, bus.busy_o}, 8'h00);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 8'h80);
            if (i < 5) cmp("midrst_hold", bus.x_o, 8'h00);
        end
        cmp("midrst_upd", bus.x_o, 8'h80);

        // Bounce on lane 0 every 2 cycles, then settle high.
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        rise_cnt = 0;
        prev_x0  = bus.x_o[0];
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, ((i / 2) % 2 == 0) ? 8'h01 : 8'h00);
            if (bus.x_o[0] && !prev_x0) rise_cnt++;
            prev_x0 = bus.x_o[0];
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 8'h01);
            if (bus.x_o[0] && !prev_x0) rise_cnt++;
            prev_x0 = bus.x_o[0];
            if (i < 5) cmp("bounce_hold", {7'b0, bus.x_o[0]}, 8'h00);
            if (i == 5) cmp("bounce_rise", {7'b0, bus.x_o[0]}, 8'h01);
        end
        cmp("bounce_rises", 8'(rise_cnt), 8'h01);

        // Randomized traffic checked against the model.
        sw_r     = 8'h00;
        frz_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) sw_r = sw_r ^ (8'($urandom) & 8'($urandom));
            if (frz_left > 0) frz_left--;
            else if ($urandom_range(0, 40) == 0) frz_left = int'($urandom_range(1, 8));
            r_r = ($urandom_range(0, 250) == 0);
            cycle(r_r, frz_left > 0, sw_r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_req_debounce8
